// File: rtl/gf2m_reduce.sv
// Sequential reduction of a 2*M-bit GF(2) product modulo x^M + x^K1 + x^K2 + x^K3 + 1.
// Each FOLD cycle folds the upper half back into the lower half; at most two folds are needed.
module gf2m_reduce #(
  parameter int unsigned M  = 163,
  parameter int unsigned K1 = 7,
  parameter int unsigned K2 = 6,
  parameter int unsigned K3 = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*M-1:0] in_prod,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M-1:0]   out_res,
  output logic [1:0]     fold_cnt,
  output logic           busy
);

  localparam int unsigned W = 2 * M;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Taps must stay below M/2 so that the second fold leaves nothing above degree M-1.
  generate
    if (!(M > K1 && K1 > K2 && K2 > K3 && K3 > 0 && K1 < M / 2)) begin : g_bad_params
      $error("gf2m_reduce: invalid reduction polynomial taps");
    end
  endgenerate

  state_t         state_q, state_d;
  logic [W-1:0]   r_q, r_d;
  logic [M-1:0]   out_res_q, out_res_d;
  logic [1:0]     fold_cnt_q, fold_cnt_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   r_fold;
  logic           hi_nz;
  logic           fold_hi_nz;

  function automatic logic [W-1:0] fold(input logic [W-1:0] r);
    logic [W-1:0] h;
    h    = W'(r[W-1:M]);
    fold = W'(r[M-1:0]) ^ h ^ (h << K3) ^ (h << K2) ^ (h << K1);
  endfunction

  assign r_fold     = fold(r_q);
  assign hi_nz      = (r_q[W-1:M] != '0);
  assign fold_hi_nz = (r_fold[W-1:M] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      out_res_q   <= '0;
      fold_cnt_q  <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      out_res_q   <= out_res_d;
      fold_cnt_q  <= fold_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    out_res_d   = out_res_q;
    fold_cnt_d  = fold_cnt_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          r_d        = in_prod;
          fold_cnt_d = 2'd0;
          state_d    = FOLD;
        end
      end

      FOLD: begin
        r_d = r_fold;
        if (hi_nz) fold_cnt_d = fold_cnt_q + 2'd1;
        if (!fold_hi_nz) begin
          out_res_d   = r_fold[M-1:0];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          out_valid_d = 1'b0;
          // Back-to-back accept: the next operand starts folding with no idle bubble.
          if (in_valid) begin
            r_d        = in_prod;
            fold_cnt_d = 2'd0;
            state_d    = FOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign fold_cnt  = fold_cnt_q;
  assign busy      = (state_q == FOLD);

  // Two non-trivial folds always clear the upper half, so a third FOLD cycle is a design error.
  fold_bound_a: assert property (@(posedge clk) disable iff (rst)
    (state_q == FOLD) |-> (fold_cnt_q != 2'd2));

endmodule

// File: tb/tb_gf2m_reduce.sv
// Randomized bench for gf2m_reduce against a bit-serial reference reduction.
module tb_gf2m_reduce;

  localparam int unsigned M  = 163;
  localparam int unsigned W  = 2 * M;
  localparam int unsigned K1 = 7;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_prod;
  logic           out_valid;
  logic           out_ready;
  logic [M-1:0]   out_res;
  logic [1:0]     fold_cnt;
  logic           busy;

  int errors = 0;
  int checks = 0;

  gf2m_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .fold_cnt  (fold_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Long-division style reduction: cancel each high coefficient from the top down.
  function automatic logic [W-1:0] ref_reduce(input logic [W-1:0] p);
    logic [W-1:0] t;
    t = p;
    for (int i = W - 1; i >= int'(M); i--) begin
      if (t[i]) begin
        t[i]       = 1'b0;
        t[i-163]   = ~t[i-163];
        t[i-163+3] = ~t[i-163+3];
        t[i-163+6] = ~t[i-163+6];
        t[i-163+7] = ~t[i-163+7];
      end
    end
    return t;
  endfunction

  // Folds needed follow from the degree: none below M, a second one once deg >= 2M-K1.
  function automatic int ref_folds(input logic [W-1:0] p);
    int top;
    top = -1;
    for (int i = 0; i < int'(W); i++) if (p[i]) top = i;
    if (top < int'(M)) return 0;
    if (top < int'(W - K1)) return 1;
    return 2;
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < 11; i++) v = (v << 32) | W'($urandom);
    return v;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    logic [W-1:0] one;
    int           top;
    one = W'(1);
    v   = rand_wide();
    if ($urandom_range(0, 3) != 0) begin
      top = $urandom_range(0, W - 1);
      v   = (v & ((one << top) - one)) | (one << top);
    end
    return v;
  endfunction

  // Wait (bounded) for out_valid after an accepting edge; returns edges elapsed.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 5) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] p, input int hold);
    logic [W-1:0] exp_r;
    int           exp_c;
    int           lat;
    exp_r = ref_reduce(p);
    exp_c = ref_folds(p);
    check("in_ready_idle", W'(in_ready), W'(1));
    in_prod  = p;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat);
    check("latency", W'(lat), W'((exp_c == 0) ? 1 : exp_c));
    check("out_res", W'(out_res), exp_r);
    check("fold_cnt", W'(fold_cnt), W'(exp_c));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_res", W'(out_res), exp_r);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_valid", W'(out_valid), W'(0));
  endtask

  initial begin
    logic [W-1:0] one;
    logic [W-1:0] res_a;
    logic [1:0]   cnt_a;
    int           lat;
    one       = W'(1);
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", W'(out_valid), W'(0));
    check("rst_res", W'(out_res), W'(0));
    check("rst_cnt", W'(fold_cnt), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_ready", W'(in_ready), W'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(W'(5), 0);
    run_op(one << 163, 1);
    run_op(one << 325, 0);

    // Directed constants for the single-bit cases.
    in_prod  = one << 325;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat);
    check("x325_res", W'(out_res), (one << 162) | W'(26'h2844));
    check("x325_cnt", W'(fold_cnt), W'(2));
    res_a = W'(out_res);
    cnt_a = fold_cnt;

    // Backpressure with a new operand pending on the input.
    in_prod  = one << 163;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_res", W'(out_res), res_a);
      check("bp_cnt", W'(fold_cnt), W'(cnt_a));
      check("bp_ready", W'(in_ready), W'(0));
      check("bp_valid", W'(out_valid), W'(1));
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_up", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_busy", W'(busy), W'(1));
    check("b2b_valid", W'(out_valid), W'(0));
    wait_result(lat);
    check("b2b_lat", W'(lat), W'(1));
    check("b2b_res", W'(out_res), W'(8'hC9));
    check("b2b_cnt", W'(fold_cnt), W'(1));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset during the second fold of x^325.
    in_prod  = one << 325;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_busy", W'(busy), W'(1));
    check("mid_cnt", W'(fold_cnt), W'(1));
    rst = 1'b1;
    #1;
    check("arst_valid", W'(out_valid), W'(0));
    check("arst_res", W'(out_res), W'(0));
    check("arst_cnt", W'(fold_cnt), W'(0));
    check("arst_busy", W'(busy), W'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("arst_hold", W'(out_valid), W'(0));
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_valid", W'(out_valid), W'(0));
    end
    run_op(one << 163, 0);

    run_op('0, 0);
    run_op('1, 1);
    for (int n = 0; n < 10000; n++) run_op(rand_operand(), $urandom_range(0, 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
